// File: rtl/thermo_pkg.sv
//------------------------------------------------------------------------------
// Module  : thermo_pkg
// Brief   : Shared types and constants for the thermostat demand controller
//           and the zone controllers that reuse its comparator.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package thermo_pkg;

   // Demand FSM state encoding
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      HOLDOFF = 2'd2
   } state_e;

   // Active mode encoding as seen on the status output
   localparam logic MODE_HEAT = 1'b0;
   localparam logic MODE_COOL = 1'b1;

   // Temperature words carry 4 fractional bits: 1 LSB = 1/16 degC
   localparam int TEMP_FRAC_BITS = 4;

endpackage : thermo_pkg

`default_nettype wire

// File: rtl/thermo_cmp.sv
//------------------------------------------------------------------------------
// Module  : thermo_cmp
// Brief   : Combinational hysteresis comparator. Produces demand / satisfied
//           flags for the mode selected by status_i, using sums one bit
//           wider than the temperature word so they never wrap.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module thermo_cmp
   import thermo_pkg::*;
#(
   parameter int TW = 12
) (
   input  logic [TW-1:0] target_i,
   input  logic [TW-1:0] ambient_i,
   input  logic [TW-1:0] threshold_i,
   input  logic          status_i,
   output logic          demand_o,
   output logic          sat_o
);

   logic [TW:0] tgt_w;
   logic [TW:0] amb_w;
   logic [TW:0] tgt_plus_thr_w;
   logic [TW:0] amb_plus_thr_w;
   logic        demand_cool_w;
   logic        sat_cool_w;
   logic        demand_heat_w;
   logic        sat_heat_w;

   assign tgt_w          = {1'b0, target_i};
   assign amb_w          = {1'b0, ambient_i};
   assign tgt_plus_thr_w = tgt_w + {1'b0, threshold_i};
   assign amb_plus_thr_w = amb_w + {1'b0, threshold_i};

   // Cooling wants the room at least one band above the setpoint to start,
   // and stops once the room has come down to the setpoint.
   assign demand_cool_w = (tgt_plus_thr_w <= amb_w);
   assign sat_cool_w    = (tgt_w >= amb_w);

   // Heating mirrors that: start one band below, stop at the setpoint.
   assign demand_heat_w = (tgt_w >= amb_plus_thr_w);
   assign sat_heat_w    = (tgt_w <= amb_w);

   // Select the flag pair belonging to the active mode
   always_comb begin
      demand_o = demand_heat_w;
      sat_o    = sat_heat_w;
      if (status_i == MODE_COOL) begin
         demand_o = demand_cool_w;
         sat_o    = sat_cool_w;
      end
   end

endmodule : thermo_cmp

`default_nettype wire

// File: rtl/thermo_demand_ctrl.sv
//------------------------------------------------------------------------------
// Module  : thermo_demand_ctrl
// Brief   : Turns fixed-point temperature samples into heat / cool requests
//           and an active-mode flag, with hysteresis and minimum-on /
//           minimum-off compressor protection. All outputs registered.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module thermo_demand_ctrl
   import thermo_pkg::*;
#(
   parameter int TW      = 12,
   parameter int CW      = 8,
   parameter int MIN_ON  = 4,
   parameter int MIN_OFF = 3
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          sample_valid_i,
   input  logic [TW-1:0] target_i,
   input  logic [TW-1:0] ambient_i,
   input  logic [TW-1:0] threshold_i,
   input  logic          mode_req_i,
   input  logic          enable_i,
   output logic          A_o,
   output logic          B_o,
   output logic          status_o,
   output logic          busy_o
);

   // Thresholds widened by one bit so a full counter still compares correctly
   localparam logic [CW:0] MIN_ON_W  = (CW+1)'(MIN_ON);
   localparam logic [CW:0] MIN_OFF_W = (CW+1)'(MIN_OFF);

   state_e        state_q,  state_d;
   logic          status_q, status_d;
   logic          a_q,      a_d;
   logic          b_q,      b_d;
   logic          busy_q,   busy_d;
   logic [CW-1:0] on_cnt_q,  on_cnt_d;
   logic [CW-1:0] off_cnt_q, off_cnt_d;

   logic          demand_w;
   logic          sat_w;
   logic [CW:0]   off_inc_w;

   // Comparator always looks at the mode registered before this edge
   thermo_cmp #(
      .TW (TW)
   ) u_cmp (
      .target_i    (target_i),
      .ambient_i   (ambient_i),
      .threshold_i (threshold_i),
      .status_i    (status_q),
      .demand_o    (demand_w),
      .sat_o       (sat_w)
   );

   assign off_inc_w = {1'b0, off_cnt_q} + 1'b1;

   // Next-state, counter and output decode for the demand FSM
   always_comb begin
      state_d   = state_q;
      status_d  = status_q;
      a_d       = a_q;
      b_d       = b_q;
      on_cnt_d  = on_cnt_q;
      off_cnt_d = off_cnt_q;

      unique case (state_q)
         IDLE: begin
            a_d      = 1'b0;
            b_d      = 1'b0;
            status_d = mode_req_i;
            if (sample_valid_i && enable_i && demand_w) begin
               // Keep the mode that was used for the decision so the
               // request and status always agree.
               state_d  = RUN;
               status_d = status_q;
               a_d      = (status_q == MODE_HEAT);
               b_d      = (status_q == MODE_COOL);
               on_cnt_d = CW'(1);
            end
         end

         RUN: begin
            if (!enable_i) begin
               // Disable wins over minimum-on protection
               state_d   = HOLDOFF;
               a_d       = 1'b0;
               b_d       = 1'b0;
               off_cnt_d = '0;
            end else if (sample_valid_i) begin
               if (on_cnt_q != '1) begin
                  on_cnt_d = on_cnt_q + 1'b1;
               end
               if (sat_w && ({1'b0, on_cnt_q} >= MIN_ON_W)) begin
                  state_d   = HOLDOFF;
                  a_d       = 1'b0;
                  b_d       = 1'b0;
                  off_cnt_d = '0;
               end
            end
         end

         HOLDOFF: begin
            a_d = 1'b0;
            b_d = 1'b0;
            if ({1'b0, off_cnt_q} >= MIN_OFF_W) begin
               // Only reachable with a zero lockout: leave after one clock
               state_d = IDLE;
            end else if (sample_valid_i) begin
               off_cnt_d = off_inc_w[CW-1:0];
               if (off_inc_w >= MIN_OFF_W) begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
            a_d     = 1'b0;
            b_d     = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         status_q  <= MODE_HEAT;
         a_q       <= 1'b0;
         b_q       <= 1'b0;
         busy_q    <= 1'b0;
         on_cnt_q  <= '0;
         off_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         status_q  <= status_d;
         a_q       <= a_d;
         b_q       <= b_d;
         busy_q    <= busy_d;
         on_cnt_q  <= on_cnt_d;
         off_cnt_q <= off_cnt_d;
      end
   end

   assign A_o      = a_q;
   assign B_o      = b_q;
   assign status_o = status_q;
   assign busy_o   = busy_q;

endmodule : thermo_demand_ctrl

`default_nettype wire

// File: tb/tb_thermo_demand_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_thermo_demand_ctrl
// Brief   : Scoreboard bench for thermo_demand_ctrl. The driver pushes the
//           expected {A,B,status,busy} after each edge; a monitor pops and
//           compares on the falling edge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_thermo_demand_ctrl;

   localparam int TW = 12;

   logic          clk;
   logic          rst_n;
   logic          sample_valid;
   logic [TW-1:0] target;
   logic [TW-1:0] ambient;
   logic [TW-1:0] threshold;
   logic          mode_req;
   logic          enable;
   logic          a_out;
   logic          b_out;
   logic          status_out;
   logic          busy_out;

   typedef struct {
      logic [3:0] exp;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   thermo_demand_ctrl #(
      .TW      (TW),
      .CW      (8),
      .MIN_ON  (4),
      .MIN_OFF (3)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .sample_valid_i (sample_valid),
      .target_i       (target),
      .ambient_i      (ambient),
      .threshold_i    (threshold),
      .mode_req_i     (mode_req),
      .enable_i       (enable),
      .A_o            (a_out),
      .B_o            (b_out),
      .status_o       (status_out),
      .busy_o         (busy_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare every pending expectation on the falling edge
   initial begin
      exp_t       e;
      logic [3:0] act;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {a_out, b_out, status_out, busy_out};
            checks++;
            if (act !== e.exp) begin
               failures++;
               $display("FAIL %s: {A,B,status,busy} got %b expected %b at %0t",
                        e.name, act, e.exp, $time);
            end
         end
      end
   end

   task automatic push(input logic [3:0] exp, input string name);
      exp_t e;
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
   endtask

   // One clock with the current inputs, then queue the expected outputs
   task automatic cyc(input logic [3:0] exp, input string name);
      @(posedge clk);
      #1;
      push(exp, name);
   endtask

   // Single sample_valid pulse followed by one quiet clock
   task automatic pulse(input logic [3:0] exp_s, input logic [3:0] exp_q,
                        input string name);
      sample_valid = 1'b1;
      cyc(exp_s, name);
      sample_valid = 1'b0;
      cyc(exp_q, {name, "_hold"});
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      target       = 12'd288;
      ambient      = 12'd416;
      threshold    = 12'd32;
      mode_req     = 1'b1;
      enable       = 1'b1;

      // Reset state
      cyc(4'b0000, "reset_state");
      cyc(4'b0000, "reset_state2");
      rst_n = 1'b1;

      // Cool demand: status loads in IDLE, then B one clock after pulse
      cyc(4'b0010, "idle_status_cool");
      pulse(4'b0111, 4'b0111, "cool_start");

      // Minimum-on hold: satisfied from the 2nd RUN sample, drop at pre-cnt 4
      pulse(4'b0111, 4'b0111, "run_s1_pre1");
      ambient = 12'd280;
      pulse(4'b0111, 4'b0111, "sat_pre2_hold");
      pulse(4'b0111, 4'b0111, "sat_pre3_hold");
      pulse(4'b0011, 4'b0011, "sat_pre4_drop");

      // Holdoff lockout with cooling demand present on every sample
      ambient = 12'd416;
      pulse(4'b0011, 4'b0011, "holdoff_s1");
      pulse(4'b0011, 4'b0011, "holdoff_s2");
      pulse(4'b0010, 4'b0010, "holdoff_to_idle");
      pulse(4'b0111, 4'b0111, "cool_restart");

      // Mode change during RUN is ignored; enable=0 forces exit without sample
      mode_req = 1'b0;
      pulse(4'b0111, 4'b0111, "mode_frozen_run");
      enable = 1'b0;
      cyc(4'b0011, "enable_off_exit");
      enable = 1'b1;
      pulse(4'b0011, 4'b0011, "ovr_holdoff_s1");
      pulse(4'b0011, 4'b0011, "ovr_holdoff_s2");
      sample_valid = 1'b1;
      cyc(4'b0010, "ovr_to_idle_status_old");
      sample_valid = 1'b0;
      cyc(4'b0000, "idle_status_heat");

      // Heat hysteresis: 260 is inside the band, 256 reaches its edge
      ambient = 12'd260;
      pulse(4'b0000, 4'b0000, "heat_in_band");
      ambient = 12'd256;
      enable  = 1'b0;
      pulse(4'b0000, 4'b0000, "heat_disabled_idle");
      enable  = 1'b1;
      pulse(4'b1001, 4'b1001, "heat_start");
      ambient = 12'd300;
      pulse(4'b1001, 4'b1001, "heat_sat_pre1");
      pulse(4'b1001, 4'b1001, "heat_sat_pre2");
      pulse(4'b1001, 4'b1001, "heat_sat_pre3");
      pulse(4'b0001, 4'b0001, "heat_sat_pre4_drop");
      pulse(4'b0001, 4'b0001, "heat_holdoff_s1");
      pulse(4'b0001, 4'b0001, "heat_holdoff_s2");
      pulse(4'b0000, 4'b0000, "heat_to_idle");

      // Async reset while B=1
      mode_req = 1'b1;
      ambient  = 12'd416;
      cyc(4'b0010, "pre_reset_status");
      pulse(4'b0111, 4'b0111, "pre_reset_cool");
      mode_req = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      push(4'b0000, "async_reset_immediate");
      cyc(4'b0000, "async_reset_held");
      rst_n = 1'b1;
      pulse(4'b0000, 4'b0000, "post_reset_no_demand");
      mode_req = 1'b1;
      cyc(4'b0010, "post_reset_status");
      pulse(4'b0111, 4'b0111, "post_reset_cool");

      // Drain the scoreboard within a bounded number of clocks
      guard = 0;
      while (sb_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      if (sb_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_thermo_demand_ctrl

`default_nettype wire

// File: doc/thermo_demand_ctrl.md
Name: thermo_demand_ctrl

Overview:
- Upstream stage of heating_dut: generates its A (heat request), B (cool request) and status (mode) inputs from fixed-point temperature samples.
- Implements hysteresis comparison plus minimum-on / minimum-off compressor protection with a 3-state FSM.
- Replaces behavioural real-number demand logic with synthesizable unsigned fixed-point arithmetic.

Parameters:
- TW, 12, temperature word width; unsigned, 1 LSB = 1/16 degC (18.0 degC = 288).
- CW, 8, width of on/off sample counters.
- MIN_ON, 4, minimum RUN duration in accepted samples before demand may be dropped.
- MIN_OFF, 3, samples spent in HOLDOFF before a new demand is accepted.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe: target/ambient/threshold valid this cycle.
- target  in  TW  setpoint temperature.
- ambient  in  TW  measured room temperature.
- threshold  in  TW  hysteresis band.
- mode_req  in  1  requested mode: 1 = cooling, 0 = heating.
- enable  in  1  system enable; 0 forces demand off.
- A  out  1  heat request to heating_dut.
- B  out  1  cool request to heating_dut.
- status  out  1  active mode to heating_dut: 1 = cooling, 0 = heating.
- busy  out  1  high in RUN or HOLDOFF.

Behaviour:
- Reset (rst=0, async): state=IDLE, A=0, B=0, status=0, busy=0, on_cnt=0, off_cnt=0.
- All outputs are registered.
- Latency: 1 clock from the deciding sample_valid cycle to the output change.
- Comparisons use TW+1-bit sums, so target+threshold and ambient+threshold never wrap.
  - demand_cool = (target+threshold <= ambient).
  - sat_cool = (target >= ambient).
  - demand_heat = (target >= ambient+threshold).
  - sat_heat = (target <= ambient).
- demand and sat refer to the active mode selected by status.
- status:
  - Loads mode_req on every clock while state=IDLE.
  - Frozen in RUN and HOLDOFF; a mode change during RUN takes effect only after return to IDLE.
- A and B are never both 1. A=1 only when status=0; B=1 only when status=1.
- The FSM advances only on sample_valid cycles, except for the enable=0 forced exit (last case under RUN).
- IDLE:
  - On sample_valid with enable=1 and demand true: go to RUN, assert A (status=0) or B (status=1), on_cnt=1.
  - Decision uses the status value registered before this edge.
- RUN:
  - Each sample_valid increments on_cnt, saturating at 2^CW-1.
  - On sample_valid with sat true and on_cnt >= MIN_ON: go to HOLDOFF, A=B=0, off_cnt=0.
    - on_cnt here is the pre-increment value.
  - sat true with on_cnt < MIN_ON: remain in RUN, request held.
  - enable=0 in any cycle, sample_valid not required: immediate exit to HOLDOFF, A=B=0. This overrides MIN_ON.
- HOLDOFF:
  - A=B=0. Each sample_valid increments off_cnt.
  - When off_cnt reaches MIN_OFF: go to IDLE.
  - No demand is evaluated on the transition sample; the next sample is evaluated in IDLE.
- busy = (state != IDLE).
- sample_valid with enable=0 in IDLE: no effect.
- MIN_ON=0: sat exits RUN on the first satisfying sample.
- MIN_OFF=0: HOLDOFF lasts exactly one clock, then IDLE.
- Async reset mid-RUN: A/B drop immediately, with no HOLDOFF.

Decomposition:
- Shared package thermo_pkg:
  - state encoding: IDLE=2'd0, RUN=2'd1, HOLDOFF=2'd2.
  - MODE_HEAT=1'b0, MODE_COOL=1'b1.
  - temperature LSB constant TEMP_FRAC_BITS=4.
- One sub-module: thermo_cmp.
  - Combinational.
  - Inputs: target, ambient, threshold, status.
  - Outputs: demand, sat.
  - Uses widened arithmetic.
  - Reused by later zone controllers.
- FSM and counters stay in thermo_demand_ctrl.

Test Plan:
- Cool demand:
  - Stimulus: mode_req=1, enable=1, target=288, threshold=32, ambient=416; pulse sample_valid.
  - Response: status=1 before the pulse; B=1 one clock after the pulse; A=0; busy=1.
- MIN_ON hold:
  - Stimulus: from cool RUN, ambient=280 on the 2nd sample.
  - Response: B stays 1 through sample 4; B=0 one clock after the sample where pre-increment on_cnt=4; state HOLDOFF.
- Heat hysteresis band:
  - Stimulus: mode_req=0, target=288, threshold=32, ambient=260 (band edge not reached).
  - Response: A stays 0.
  - Then ambient=256 → A=1.
  - Then ambient=300 after MIN_ON samples → A=0.
- HOLDOFF lockout:
  - Stimulus: right after demand drop, reapply ambient=416 (cool mode) on every sample.
  - Response: B stays 0 for 3 samples; B=1 on the first sample after return to IDLE.
- Enable/mode override:
  - Stimulus: mode_req toggled to 0 during cool RUN.
  - Response: status stays 1.
  - Stimulus: enable=0 mid-RUN, no sample_valid.
  - Response: B=0 next clock; status becomes 0 only after HOLDOFF→IDLE.
- Async reset:
  - Stimulus: assert rst=0 between clock edges while B=1.
  - Response: B, A, status, busy = 0 immediately; all stay 0 until first post-reset demanding sample.
